uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single UART transmitter among NREQ byte requesters. It sits between the requesters and the transmitter's newd/data/done handshake. It latches one requester's byte and holds the transmitter's new-data strobe long enough for the slow baud-clock domain to capture it. It then waits for the done edge, or a timeout, before serving the next requester.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ byte requesters
// Holds tx_newd long enough for the baud-clock domain, then waits for a done edge or a timeout.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int HOLD_CYC    = 120,
  parameter int TIMEOUT_CYC = 2048,
  parameter int GAP_CYC     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done_pulse,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic                     err,
  output logic                     tx_newd,
  output logic [DW-1:0]            tx_data,
  input  logic                     tx_done
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_SAT    = TW'(TIMEOUT_CYC);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     owner_q;
  logic [HW-1:0]     hold_q;
  logic [TW-1:0]     to_q;
  logic [TW-1:0]     to_d;
  logic [GW-1:0]     gap_q;
  logic              done_seen_q;
  logic              tx_done_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_pulse_q;
  logic              busy_q;
  logic              err_q;
  logic              tx_newd_q;
  logic [DW-1:0]     tx_data_q;

  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic              done_edge;
  logic              timeout_hit;
  logic [DW-1:0]     lanes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lanes[i] = req_data[i*DW +: DW];
  end

  // Rotating priority search starting at ptr_q, wrapping through NREQ-1 back to 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign done_edge   = tx_done & ~tx_done_q;
  assign timeout_hit = (to_q == TO_LAST);
  assign to_d        = (to_q == TO_SAT) ? to_q : to_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      hold_q       <= '0;
      to_q         <= '0;
      gap_q        <= '0;
      done_seen_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      gnt_q        <= '0;
      done_pulse_q <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      tx_newd_q    <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      tx_done_q    <= tx_done;
      gnt_q        <= '0;
      done_pulse_q <= '0;
      to_q         <= to_d;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt_q       <= NREQ'(1) << win_idx;
            owner_q     <= win_idx;
            tx_data_q   <= lanes[win_idx];
            tx_newd_q   <= 1'b1;
            ptr_q       <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            hold_q      <= '0;
            to_q        <= '0;
            done_seen_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (hold_q == HOLD_LAST) begin
            tx_newd_q <= 1'b0;
            // A done edge caught during the hold completes the byte as soon as the strobe drops.
            if (done_seen_q || done_edge) begin
              done_pulse_q <= NREQ'(1) << owner_q;
              gap_q        <= '0;
              state_q      <= S_GAP;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
            if (done_edge) done_seen_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (done_edge || done_seen_q) begin
            done_pulse_q <= NREQ'(1) << owner_q;
            gap_q        <= '0;
            state_q      <= S_GAP;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done_pulse = done_pulse_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign tx_newd    = tx_newd_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Transfer-level model timed by cycles since grant, compared every cycle, plus directed literal checks.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int HOLD = 120;
  localparam int TMO  = 2048;
  localparam int GAP  = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_done = 1'b0;
  logic [3:0]  gnt, done_pulse;
  logic [1:0]  owner;
  logic        busy, err, tx_newd;
  logic [7:0]  tx_data;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done_pulse(done_pulse),
    .owner(owner), .busy(busy), .err(err), .tx_newd(tx_newd), .tx_data(tx_data), .tx_done(tx_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
  endtask

  // Transfer model: m_k = cycles since the grant cycle; m_first = first done edge; m_endk = resolution cycle.
  logic       m_active = 1'b0;
  int         m_k = 0, m_first = -1, m_endk = -1, m_ptr = 0;
  logic       m_prev = 1'b0;
  logic [3:0] e_gnt = '0, e_pulse = '0;
  logic [1:0] e_owner = '0;
  logic [7:0] e_data = '0;
  logic       e_busy = 1'b0, e_err = 1'b0, e_newd = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic de;
    int   w;
    e_gnt   = '0;
    e_pulse = '0;
    if (!rst) begin
      m_active = 1'b0; m_ptr = 0; m_prev = 1'b0;
      e_owner = '0; e_data = '0; e_busy = 1'b0; e_err = 1'b0; e_newd = 1'b0;
      return;
    end
    de = tx_done && !m_prev;
    m_prev = tx_done;
    if (!m_active) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_active = 1'b1; m_k = 0; m_first = -1; m_endk = -1;
        e_gnt   = 4'(1 << w);
        e_owner = 2'(w);
        e_data  = req_data[w*8 +: 8];
        m_ptr   = (w + 1) % NREQ;
      end
    end else begin
      m_k++;
      if (m_endk < 0) begin
        if (m_first < 0 && de) m_first = m_k;
        if (m_first >= 0 && m_k >= HOLD) begin
          e_pulse = 4'(1 << e_owner);
          m_endk  = m_k;
        end else if (m_k >= TMO) begin
          e_err  = 1'b1;
          m_endk = m_k;
        end
      end else if (m_k >= m_endk + GAP + 1) begin
        m_active = 1'b0;
      end
    end
    e_busy = m_active;
    e_newd = m_active && (m_k < HOLD);
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  int run = 0, last_run = 0, pulse_cnt = 0;

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("done_pulse", 32'(done_pulse), 32'(e_pulse));
      chk("owner", 32'(owner), 32'(e_owner));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("err", 32'(err), 32'(e_err));
      chk("tx_newd", 32'(tx_newd), 32'(e_newd));
      chk("tx_data", 32'(tx_data), 32'(e_data));
      if (tx_newd) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      if (done_pulse != '0) pulse_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int j = 0; j < NREQ; j++) if (gnt[j]) idx = j;
        break;
      end
    end
    chk("grant_seen", 32'(idx >= 0), 32'd1);
  endtask

  task automatic serve(output int idx, input logic [3:0] after);
    wait_gnt(idx);
    step(1);
    req = after;
    step(HOLD + 3);
    tx_done = 1'b1;
    step(2);
    tx_done = 1'b0;
  endtask

  task automatic wait_err(output int c);
    c = 0;
    for (int i = 1; i <= TMO + 100; i++) begin
      @(negedge clk);
      if (err) begin
        c = i;
        break;
      end
    end
  endtask

  int idx, c, pc;
  int order [5];

  initial begin : main
    step(3);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_newd", 32'(tx_newd), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    step(1);
    rst = 1'b1;
    step(2);

    // Single request on lane 1
    req_data = 32'h4433_A511;
    req = 4'b0010;
    wait_gnt(idx);
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_owner", 32'(owner), 32'd1);
    step(1);
    req = '0;
    step(HOLD + 5);
    chk("t1_newd_len", 32'(last_run), 32'(HOLD));
    tx_done = 1'b1;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_pulse != '0) begin
        c = 1;
        break;
      end
    end
    chk("t1_pulse", 32'(done_pulse), 32'h2);
    @(negedge clk);
    chk("t1_pulse_1cyc", 32'(done_pulse), 32'd0);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_owner_kept", 32'(owner), 32'd1);
    step(1);
    tx_done = 1'b0;

    // Round robin with all four requesting
    do_reset();
    req_data = 32'hD3C2_B1A0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(idx, (i == 4) ? 4'b0000 : 4'b1111);
      order[i] = idx;
    end
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), 32'(order[i]), 32'(i % 4));

    // Pointer wrap after a grant to 3
    do_reset();
    req = 4'b1000;
    serve(idx, 4'b1001);
    chk("t3_first", 32'(idx), 32'd3);
    serve(idx, 4'b1001);
    chk("t3_wrap0", 32'(idx), 32'd0);
    serve(idx, 4'b0000);
    chk("t3_then3", 32'(idx), 32'd3);
    step(4);

    // Timeout with tx_done held low
    req = 4'b0001;
    wait_gnt(idx);
    req = '0;
    pc = pulse_cnt;
    wait_err(c);
    chk("t4_err_cycle", 32'(c), 32'(TMO));
    chk("t4_no_pulse", 32'(pulse_cnt), 32'(pc));
    req = 4'b0100;
    serve(idx, 4'b0000);
    chk("t4_next_served", 32'(idx), 32'd2);
    chk("t4_err_sticky", 32'(err), 32'd1);
    step(4);

    // Stale done level: no edge, so timeout; then fall/rise during ISSUE
    do_reset();
    @(negedge clk);
    chk("t5_err_cleared", 32'(err), 32'd0);
    tx_done = 1'b1;
    step(2);
    req = 4'b0001;
    wait_gnt(idx);
    req = '0;
    pc = pulse_cnt;
    wait_err(c);
    chk("t5_stale_timeout", 32'(c), 32'(TMO));
    chk("t5_stale_no_pulse", 32'(pulse_cnt), 32'(pc));
    step(3);
    req = 4'b0010;
    wait_gnt(idx);
    req = '0;
    c = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 10) tx_done = 1'b0;
      if (i == 20) tx_done = 1'b1;
      if (done_pulse != '0) begin
        c = i;
        break;
      end
    end
    chk("t5_latched_pulse_cycle", 32'(c), 32'(HOLD));
    chk("t5_latched_pulse_val", 32'(done_pulse), 32'h2);
    tx_done = 1'b0;
    step(4);

    // Reset in the middle of the hold
    req = 4'b0100;
    wait_gnt(idx);
    req = '0;
    repeat (50) @(negedge clk);
    pc = pulse_cnt;
    step(1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_newd", 32'(tx_newd), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    req = 4'b1111;
    wait_gnt(idx);
    chk("t6_ptr_zero", 32'(idx), 32'd0);
    req = '0;
    step(HOLD + 20);
    chk("t6_no_pulse", 32'(pulse_cnt), 32'(pc));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
